// File: rtl/vin_line_writer.sv
// Input-side line writer: writes the incoming pixel stream into a ring of
// line buffers and publishes {completed_lines, x} for the output side.
module vin_line_writer #(
    parameter int DATA_W  = 24,
    parameter int LINES   = 4,
    parameter int LINE_AW = 2
) (
    input  logic              vin_clk,
    input  logic              rst,
    input  logic              frame_sync_n,
    input  logic [15:0]       vin_xres,
    input  logic [15:0]       vin_yres,
    input  logic              vin_de,
    input  logic [DATA_W-1:0] vin_data,
    input  logic [15:0]       rd_line_y,
    output logic [31:0]       vin_addr,
    output logic              wr_en,
    output logic [LINE_AW-1:0] wr_line,
    output logic [15:0]       wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_done,
    output logic              err_short,
    output logic              err_long,
    output logic              err_ovr
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t      state;
    logic [15:0] xres_l;
    logic [15:0] yres_l;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] lines;
    logic        de_d;
    logic        burst_full;

    logic        accept;
    logic        last_px;
    logic        fall;
    logic        line_end;
    logic [15:0] y_next;
    logic [15:0] lag;
    logic        ovr_hit;

    assign vin_addr = {lines, x};

    always_comb begin
        accept   = (state == ACTIVE) && vin_de && (x < xres_l);
        last_px  = accept && (x == xres_l - 16'd1);
        fall     = (state == ACTIVE) && !vin_de && de_d
                   && (x != 16'd0) && (x < xres_l);
        line_end = last_px || fall;
        y_next   = y + 16'd1;
        lag      = y - rd_line_y;
        // A consumer ahead of the writer (rd_line_y > y) is never an overrun.
        ovr_hit  = accept && (x == 16'd0) && (rd_line_y <= y)
                   && (lag >= 16'(LINES));
    end

    always_ff @(posedge vin_clk) begin
        if (rst || !frame_sync_n) begin
            state      <= IDLE;
            xres_l     <= '0;
            yres_l     <= '0;
            x          <= '0;
            y          <= '0;
            lines      <= '0;
            de_d       <= 1'b0;
            burst_full <= 1'b0;
            wr_en      <= 1'b0;
            wr_line    <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            err_ovr    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    xres_l <= vin_xres;
                    yres_l <= vin_yres;
                    x      <= '0;
                    y      <= '0;
                    if (vin_xres == 16'd0 || vin_yres == 16'd0)
                        state <= DONE;
                    else
                        state <= ACTIVE;
                end
                ACTIVE: begin
                    de_d  <= vin_de;
                    // Count trails y by a cycle so the last write is in RAM first.
                    lines <= y;
                    if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= x;
                        wr_line <= y[LINE_AW-1:0];
                        wr_data <= vin_data;
                        x       <= x + 16'd1;
                        if (x == 16'd0 && burst_full)
                            err_long <= 1'b1;
                        if (ovr_hit)
                            err_ovr <= 1'b1;
                    end
                    if (!vin_de)
                        burst_full <= 1'b0;
                    else if (last_px)
                        burst_full <= 1'b1;
                    if (fall)
                        err_short <= 1'b1;
                    if (line_end) begin
                        x <= '0;
                        y <= y_next;
                        if (y_next == yres_l)
                            state <= DONE;
                    end
                end
                DONE: begin
                    lines      <= yres_l;
                    x          <= '0;
                    frame_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vin_line_writer.sv
// Scoreboard bench for vin_line_writer: a per-pixel reference model queues
// expected writes, a negedge monitor pops and compares them.
module tb_vin_line_writer;

    logic        vin_clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_sync_n = 1'b1;
    logic [15:0] vin_xres = '0;
    logic [15:0] vin_yres = '0;
    logic        vin_de = 1'b0;
    logic [23:0] vin_data = '0;
    logic [15:0] rd_line_y = '0;
    logic [31:0] vin_addr;
    logic        wr_en;
    logic [1:0]  wr_line;
    logic [15:0] wr_addr;
    logic [23:0] wr_data;
    logic        frame_done;
    logic        err_short;
    logic        err_long;
    logic        err_ovr;

    vin_line_writer #(.DATA_W(24), .LINES(4), .LINE_AW(2)) dut (
        .vin_clk(vin_clk), .rst(rst), .frame_sync_n(frame_sync_n),
        .vin_xres(vin_xres), .vin_yres(vin_yres), .vin_de(vin_de),
        .vin_data(vin_data), .rd_line_y(rd_line_y), .vin_addr(vin_addr),
        .wr_en(wr_en), .wr_line(wr_line), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_done(frame_done), .err_short(err_short),
        .err_long(err_long), .err_ovr(err_ovr)
    );

    always #5 vin_clk = ~vin_clk;

    typedef struct packed {
        logic [1:0]  line;
        logic [15:0] addr;
        logic [23:0] data;
        logic        ovr;
        logic        lng;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail = 0;

    // reference model state
    int  m_x, m_y, m_xres, m_yres;
    bit  m_short, m_long, m_ovr, m_full_burst, m_prev_de;
    bit  rd_track;
    logic [15:0] rd_const;
    bit  cnt_timing;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // monitor
    logic        p_wr_en = 1'b0;
    logic [15:0] p_wr_addr = '0;
    logic [15:0] p_cnt = '0;
    always @(negedge vin_clk) begin
        exp_t e;
        if (wr_en) begin
            if (q.size() == 0) begin
                check("unexpected_wr", {wr_line, wr_addr, wr_data}, 0);
            end else begin
                e = q.pop_front();
                check("wr_beat", {wr_line, wr_addr, wr_data, err_ovr, err_long}, e);
            end
        end
        if (cnt_timing && vin_addr[31:16] != p_cnt && vin_addr[31:16] != 0)
            check("cnt_after_last_wr", {p_wr_en, p_wr_addr},
                  {1'b1, 16'(m_xres - 1)});
        p_wr_en   <= wr_en;
        p_wr_addr <= wr_addr;
        p_cnt     <= vin_addr[31:16];
    end

    // One cycle of stimulus; the model consumes the same value the DUT will sample.
    task automatic drive(input bit de, input logic [23:0] d);
        logic [15:0] rd;
        exp_t e;
        rd = rd_track ? 16'(m_y - 1) : rd_const;
        if (m_y < m_yres && m_xres > 0) begin
            if (de) begin
                if (m_x == 0) begin
                    if (m_full_burst) m_long = 1;
                    if (int'(rd) <= m_y && m_y - int'(rd) >= 4) m_ovr = 1;
                end
                e.line = 2'(m_y % 4);
                e.addr = 16'(m_x);
                e.data = d;
                e.ovr  = m_ovr;
                e.lng  = m_long;
                q.push_back(e);
                m_x++;
                if (m_x == m_xres) begin
                    m_x = 0;
                    m_y++;
                    m_full_burst = 1;
                end
            end else begin
                if (m_prev_de && m_x > 0) begin
                    m_short = 1;
                    m_x = 0;
                    m_y++;
                end
                m_full_burst = 0;
            end
        end
        m_prev_de = de;
        @(posedge vin_clk);
        #1;
        vin_de    = de;
        vin_data  = d;
        rd_line_y = rd;
    endtask

    task automatic burst(input int n, input int gap);
        for (int i = 0; i < n; i++) drive(1'b1, 24'($urandom));
        for (int i = 0; i < gap; i++) drive(1'b0, 24'h0);
    endtask

    task automatic start_frame(input int xr, input int yr);
        rst = 1'b1;
        vin_de = 1'b0;
        vin_xres = 16'(xr);
        vin_yres = 16'(yr);
        @(posedge vin_clk);
        @(posedge vin_clk);
        #1;
        rst = 1'b0;
        m_x = 0; m_y = 0; m_xres = xr; m_yres = yr;
        m_short = 0; m_long = 0; m_ovr = 0;
        m_full_burst = 0; m_prev_de = 0;
        drive(1'b0, 24'h0);
    endtask

    task automatic end_frame(input string nm);
        bit done;
        for (int i = 0; i < 4; i++) drive(1'b0, 24'h0);
        @(negedge vin_clk);
        done = (m_y >= m_yres) || m_xres == 0 || m_yres == 0;
        check({nm, "_done"}, frame_done, done);
        check({nm, "_addr"}, vin_addr,
              done ? {16'(m_yres), 16'h0} : {16'(m_y), 16'(m_x)});
        check({nm, "_errs"}, {err_short, err_long, err_ovr},
              {m_short, m_long, m_ovr});
        check({nm, "_drained"}, q.size(), 0);
    endtask

    task automatic check_zero(input string nm);
        check(nm, {vin_addr, wr_en, wr_line, wr_addr, wr_data,
                   frame_done, err_short, err_long, err_ovr}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_track = 0;
        rd_const = '0;
        cnt_timing = 0;
        @(posedge vin_clk);
        @(negedge vin_clk);
        check_zero("reset_state");

        // clean 4x3 frame, count must follow last write by one cycle
        cnt_timing = 1;
        start_frame(4, 3);
        for (int l = 0; l < 3; l++) burst(4, 2);
        end_frame("basic");
        cnt_timing = 0;

        // short line
        start_frame(4, 3);
        burst(3, 2);
        burst(4, 1);
        burst(4, 1);
        end_frame("short");

        // long burst of 6
        start_frame(4, 3);
        burst(6, 2);
        end_frame("long");

        // overrun with consumer stuck at line 0
        rd_const = 16'd0;
        start_frame(2, 8);
        for (int l = 0; l < 5; l++) burst(2, 1);
        end_frame("ovr");

        // consumer tracking y-1
        rd_track = 1;
        start_frame(2, 8);
        for (int l = 0; l < 8; l++) burst(2, 1);
        end_frame("ovr_track");
        rd_track = 0;

        // zero width: straight to DONE, no writes
        start_frame(0, 3);
        burst(5, 1);
        end_frame("zero_x");

        // reset mid-line, then a fresh frame
        start_frame(4, 3);
        drive(1'b1, 24'h111111);
        drive(1'b1, 24'h222222);
        @(posedge vin_clk);
        #1;
        rst = 1'b1;
        vin_de = 1'b0;
        @(posedge vin_clk);
        @(negedge vin_clk);
        check_zero("rst_midline");
        check("rst_drained", q.size(), 0);
        start_frame(4, 2);
        for (int l = 0; l < 2; l++) burst(4, 1);
        end_frame("after_rst");

        // frame_sync_n pulse after DONE with errors set
        start_frame(3, 2);
        burst(2, 1);
        burst(5, 1);
        end_frame("pre_sync");
        @(posedge vin_clk);
        #1;
        frame_sync_n = 1'b0;
        @(posedge vin_clk);
        @(negedge vin_clk);
        check_zero("frame_sync");
        frame_sync_n = 1'b1;

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            rd_track = 1'($urandom_range(0, 1));
            rd_const = 16'($urandom_range(0, 7));
            start_frame($urandom_range(1, 6), $urandom_range(1, 5));
            for (int b = 0; b < 30 && m_y < m_yres; b++)
                burst($urandom_range(1, 8), $urandom_range(1, 3));
            end_frame("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vin_line_writer.md
Name: vin_line_writer

Overview:
- Input-side writer that pairs with the output coordinate generator.
- Accepts the raw input pixel stream and writes it into a LINES-deep ring of line buffers.
- Publishes vin_addr = {completed_lines, current_x}. The output side compares vin_addr[31:16] against the line it needs before it starts producing coordinates, so that field is the "lines available" count.
- Sits between the video input interface and the line-buffer RAM, in the vin_clk domain.

Parameters:
- DATA_W, 24, pixel width in bits.
- LINES, 4, number of lines in the ring buffer. Must be a power of 2 and at least 2.
- LINE_AW, 2, log2(LINES). Width of the ring line index.

Ports:
- vin_clk  in  1  pixel clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- frame_sync_n  in  1  active-low frame restart. While low, the block is held in the reset state.
- vin_xres  in  16  input active width in pixels. Sampled while in IDLE.
- vin_yres  in  16  input active height in lines. Sampled while in IDLE.
- vin_de  in  1  pixel valid.
- vin_data  in  DATA_W  pixel data.
- rd_line_y  in  16  lowest input line the consumer still needs (the consumer's coordinate_y).
- vin_addr  out  32  [31:16] = number of lines completed this frame; [15:0] = x index of the next pixel to be written.
- wr_en  out  1  line-buffer write strobe.
- wr_line  out  LINE_AW  ring slot to write; equals line number mod LINES.
- wr_addr  out  16  pixel x within the line.
- wr_data  out  DATA_W  registered copy of vin_data.
- frame_done  out  1  high once vin_yres lines have completed.
- err_short  out  1  sticky: a line ended with fewer than vin_xres pixels.
- err_long  out  1  sticky: a line received more than vin_xres pixels.
- err_ovr  out  1  sticky: a write landed in a ring slot still needed by the consumer.

Behaviour:
- Reset: rst=1 or frame_sync_n=0 (both synchronous) puts the block in IDLE with every output 0 and all counters 0. Sticky error flags also clear. Reset asserted mid-line discards the partial line; no further wr_en is issued.
- States:
  - IDLE: latch vin_xres and vin_yres. Go to ACTIVE on the next cycle in which rst=0 and frame_sync_n=1.
  - ACTIVE: accept pixels.
  - DONE: entered when line count reaches yres_l. Ignore vin_de and keep frame_done=1 until reset or frame_sync_n low.
- Pixel path (ACTIVE, vin_de=1, x < xres_l), one cycle after the sample:
  - wr_en=1, wr_addr=x, wr_line=y[LINE_AW-1:0], wr_data=vin_data.
  - x increments. All write outputs are registered, so latency is exactly 1 cycle.
- Line completion, two ways:
  - Accepting the pixel with x == xres_l-1.
  - vin_de falling (was 1, now 0) with 0 < x < xres_l. This also sets err_short.
- On completion: x returns to 0 and y increments. vin_addr[31:16] updates one cycle after that line's last wr_en, so RAM contents are committed before the consumer sees the count.
- Pixels arriving with vin_de=1 after x has wrapped because of a full line start the next line.
- Long lines: data is never dropped. err_long is set when a pixel is accepted at x=0 within the same contiguous vin_de burst that just completed a full line.
- Overrun check: at each line start, if (y - rd_line_y) >= LINES, set err_ovr. Writing proceeds anyway; the source cannot be stalled.
- Arithmetic and boundaries:
  - 16-bit unsigned throughout. The subtraction above wraps mod 2^16, and rd_line_y > y is treated as no overrun.
  - vin_addr[15:0] equals x and wraps to 0 with the line.
  - xres_l = 0 or yres_l = 0: go straight to DONE on leaving IDLE, with no writes.
  - Completion and a vin_de falling edge in the same cycle count as one completion, not two.
- After DONE, vin_addr holds {yres_l, 0}.

Test Plan:
- xres=4, yres=3, 12 pixels in 3 bursts of 4 with gaps.
  - Expect wr_addr 0..3 with wr_line 0,1,2.
  - Expect vin_addr[31:16] = 1, 2, 3, each one cycle after the line's last wr_en.
  - Expect frame_done=1 and no error flags set.
- xres=4, vin_de high for 3 pixels then low.
  - Expect line completion on the falling edge, err_short=1, next line written with wr_line=1, wr_addr restarting at 0.
- xres=4, one continuous burst of 6 pixels.
  - Expect line 0 complete, err_long=1, pixels 5 and 6 written to line 1 at wr_addr 0,1.
- LINES=4, rd_line_y held at 0, 5 full lines of xres=2.
  - Expect err_ovr=1 at the start of line 4 and not before.
  - Repeat with rd_line_y tracking y-1: err_ovr stays 0.
- Reset mid-line:
  - rst=1 after 2 pixels: all outputs 0, then a fresh frame restarts at vin_addr=0.
  - frame_sync_n=0 pulse after DONE: same result, and err flags clear.
